// File: rtl/register_file.sv
// Multi-ported register file: one synchronous write port and two combinational read ports.
// Optional hard-wired zero entry and optional same-cycle write-to-read forwarding.
module register_file #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              WE,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  datain,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  dataout1,
  output logic [WIDTH-1:0]  dataout2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_wr_zero;
  logic w_wr_en;
  logic w_fwd_ok;
  logic w_rd1_zero;
  logic w_rd2_zero;

  assign w_wr_zero  = (ZERO_REG != 0) && (waddr == '0);
  assign w_wr_en    = WE && !clr && !w_wr_zero;
  // Forwarding only when the write will actually land in storage.
  assign w_fwd_ok   = (BYPASS != 0) && w_wr_en;
  assign w_rd1_zero = (ZERO_REG != 0) && (raddr1 == '0);
  assign w_rd2_zero = (ZERO_REG != 0) && (raddr2 == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr] <= datain;
    end
  end

  always_comb begin
    dataout1 = r_mem[raddr1];
    if (w_rd1_zero) begin
      dataout1 = '0;
    end else if (w_fwd_ok && (raddr1 == waddr)) begin
      dataout1 = datain;
    end
  end

  always_comb begin
    dataout2 = r_mem[raddr2];
    if (w_rd2_zero) begin
      dataout2 = '0;
    end else if (w_fwd_ok && (raddr2 == waddr)) begin
      dataout2 = datain;
    end
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W entries.
REQ-003 The module SHALL have parameter ZERO_REG, default 1; when 1, entry 0 reads constant zero and ignores writes.
REQ-004 The module SHALL have parameter BYPASS, default 0; when 1, a read of the address being written returns datain in the same cycle.
REQ-005 The module SHALL have one clock and a synchronous, active-high reset: clk input 1 system clock, all state updates on its rising edge.
REQ-006 clr  input  1  synchronous active-high reset, sampled on rising clk.
REQ-007 WE  input  1  write enable, sampled on rising clk.
REQ-008 waddr  input  ADDR_W  write address.
REQ-009 datain  input  WIDTH  write data.
REQ-010 raddr1  input  ADDR_W  read port 1 address.
REQ-011 raddr2  input  ADDR_W  read port 2 address.
REQ-012 dataout1  output  WIDTH  read port 1 data.
REQ-013 dataout2  output  WIDTH  read port 2 data.

Function
REQ-014 Storage SHALL be 2**ADDR_W entries of WIDTH bits each.
REQ-015 Writes SHALL occur on rising clk when WE=1 and clr=0: entry[waddr] <= datain; one-cycle write latency.
REQ-016 WE=0 SHALL leave all entries unchanged.
REQ-017 Reads SHALL be combinational: dataoutN = entry[raddrN], zero clock latency, updating on any raddrN or storage change.
REQ-018 Both read ports SHALL operate independently; raddr1 = raddr2 SHALL return identical data on both ports.
REQ-019 ZERO_REG=1: a write to address 0 SHALL be discarded; reading address 0 SHALL return all zeros regardless of BYPASS.
REQ-020 ZERO_REG=0: entry 0 SHALL behave as any other entry.
REQ-021 BYPASS=0: a read of waddr in the cycle it is written SHALL return the old value; the new value appears after the rising edge.
REQ-022 BYPASS=1: when WE=1, clr=0 and raddrN = waddr (and not the zero register under ZERO_REG=1), dataoutN SHALL equal datain combinationally.
REQ-023 BYPASS SHALL NOT forward while clr=1.
REQ-024 Address widths SHALL be exact; no out-of-range address exists, since depth = 2**ADDR_W.
REQ-025 Data SHALL be stored and returned unmodified: no sign extension, truncation or shift.

Reset
REQ-026 clr=1 at a rising clk edge SHALL clear every entry to zero in that single cycle.
REQ-027 clr SHALL take priority over WE: a simultaneous write is discarded.
REQ-028 After the reset edge, dataout1 and dataout2 SHALL read zero for every address until written.
REQ-029 Reset asserted between writes SHALL lose all prior contents; no entry retains data.
REQ-030 Asserting clr without a clk edge SHALL have no effect; reset is synchronous.

Verification
REQ-031 Bench SHALL cover reset then read-all: clr=1 for one edge, sweep raddr1/raddr2 over 0..31 -> all outputs 32'h0.
REQ-032 Bench SHALL cover write/read: WE=1, waddr=5, datain=32'hDEADBEEF, edge; raddr1=5 -> dataout1=32'hDEADBEEF; raddr2=6 -> 32'h0.
REQ-033 Bench SHALL cover the zero register: ZERO_REG=1, write 32'hFFFFFFFF to waddr=0 -> dataout1 at raddr1=0 stays 32'h0; repeat with ZERO_REG=0 -> 32'hFFFFFFFF.
REQ-034 Bench SHALL cover same-cycle read of write address with entry 7 = 32'h11111111, WE=1, waddr=7, datain=32'h22222222, raddr1=7 before edge: BYPASS=0 -> 32'h11111111; BYPASS=1 -> 32'h22222222; after edge -> 32'h22222222 in both.
REQ-035 Bench SHALL cover reset vs write: clr=1 and WE=1, waddr=3, datain=32'h12345678 on same edge -> entry 3 reads 32'h0; all other entries zero.
REQ-036 Bench SHALL cover the parameter sweep: WIDTH=8, ADDR_W=3, write 8'hA5 to address 7 -> dataout2=8'hA5 at raddr2=7; other addresses read 8'h00.
